// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift unit: shift modes, directions and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC  = 2'b00,
    MODE_ARITH  = 2'b01,
    MODE_ROT    = 2'b10,
    MODE_SERIAL = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position combinational shift step. Rotate fill is built only when SEQ_SHIFT_ROTATE_EN
// is defined; otherwise rotate mode fills with zero like logical mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_vec,
  output logic             bit_out
);

  logic fill_s;

  // Select the bit leaving the vector, the bit entering it, and assemble the shifted value.
  always_comb begin
    bit_out  = 1'b0;
    fill_s   = 1'b0;
    next_vec = vec;

    if (dir == DIR_RIGHT) begin
      bit_out = vec[0];
    end else begin
      bit_out = vec[WIDTH-1];
    end

    case (mode)
      MODE_LOGIC: fill_s = 1'b0;
      MODE_ARITH: begin
        if (dir == DIR_RIGHT) begin
          fill_s = vec[WIDTH-1];
        end else begin
          fill_s = 1'b0;
        end
      end
`ifdef SEQ_SHIFT_ROTATE_EN
      MODE_ROT:    fill_s = bit_out;
`else
      MODE_ROT:    fill_s = 1'b0;
`endif
      MODE_SERIAL: fill_s = serial_in;
      default:     fill_s = 1'b0;
    endcase

    if (dir == DIR_RIGHT) begin
      next_vec = {fill_s, vec[WIDTH-1:1]};
    end else begin
      next_vec = {vec[WIDTH-2:0], fill_s};
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift register: parallel load, N-position shift command, one bit per clock.
// Rotate mode is available only with SEQ_SHIFT_ROTATE_EN defined (see shift_step).
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);
  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

  state_t           state_r;
  logic [AMT_W-1:0] cnt_r;
  logic             dir_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] data_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] step_vec_s;
  logic             step_bit_s;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .vec       (data_r),
    .dir       (dir_r),
    .mode      (mode_r),
    .serial_in (serial_in),
    .next_vec  (step_vec_s),
    .bit_out   (step_bit_s)
  );

  // Control FSM, down-counter and data/carry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      data_r  <= '0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (load) begin
            data_r  <= data_in;
            carry_r <= 1'b0;
          end else if (start) begin
            cnt_r  <= amt;
            dir_r  <= dir;
            mode_r <= mode;
            if (amt != CNT_ZERO) begin
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          data_r  <= step_vec_s;
          carry_r <= step_bit_s;
          cnt_r   <= cnt_r - CNT_ONE;
          // The counter still holds the pre-decrement value, so 1 marks the final step.
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_r;
  assign carry_out = carry_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: stimulus queues expected results, a monitor checks them on done.
// Rotate expectations follow SEQ_SHIFT_ROTATE_EN.
module tb_seq_shift_unit;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       start;
  logic [3:0] amt;
  logic       dir;
  logic [1:0] mode;
  logic       serial_in;
  logic [7:0] data_out;
  logic       carry_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    int         busy_cycles;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  int    busy_cnt = 0;
  logic  prev_done = 1'b0;
  string cur_name = "reset";

  seq_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .start     (start),
    .amt       (amt),
    .dir       (dir),
    .mode      (mode),
    .serial_in (serial_in),
    .data_out  (data_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks protocol invariants.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check({cur_name, "_busy_with_done"}, 32'(busy), 32'd0);
        check({cur_name, "_done_width"}, 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_unexpected_done actual=done required=no_done", cur_name);
        end else begin
          mon_e = sb_q.pop_front();
          check({cur_name, "_data"}, 32'(data_out), 32'(mon_e.data));
          check({cur_name, "_carry"}, 32'(carry_out), 32'(mon_e.carry));
          check({cur_name, "_busy_cycles"}, 32'(busy_cnt), 32'(mon_e.busy_cycles));
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic do_load(input logic [7:0] val);
    @(negedge clk);
    load    = 1'b1;
    data_in = val;
    @(negedge clk);
    load = 1'b0;
    check("load_data", 32'(data_out), 32'(val));
    check("load_carry", 32'(carry_out), 32'd0);
  endtask

  task automatic do_shift(input string name, input logic [3:0] a, input logic d, input logic [1:0] m,
                          input logic [7:0] ed, input logic ec, input logic [3:0] pat, input logic poke);
    exp_t e;
    int   cyc;
    int   sidx;
    bit   seen;
    e.data = ed;
    e.carry = ec;
    e.busy_cycles = int'(a);
    sb_q.push_back(e);
    cur_name = name;
    @(negedge clk);
    amt   = a;
    dir   = d;
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    amt   = 4'hF;
    dir   = ~d;
    mode  = ~m;
    cyc   = 1;
    sidx  = 0;
    seen  = 1'b0;
    while (!seen && cyc < 40) begin
      if (done) begin
        seen = 1'b1;
        check({name, "_done_latency"}, 32'(cyc), 32'(a) + 32'd1);
        if (poke) begin
          load = 1'b1; start = 1'b1; data_in = 8'hFF;
        end
      end else begin
        if (busy) begin
          serial_in = (sidx < 4) ? pat[sidx] : 1'b0;
          sidx++;
          if (poke) begin
            load = 1'b1; start = 1'b1; data_in = 8'hFF;
          end
        end
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        cyc++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    serial_in = 1'b0;
    check({name, "_hold_data"}, 32'(data_out), 32'(ed));
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; load = 1'b0; data_in = 8'h00; start = 1'b0;
    amt = 4'h0; dir = 1'b0; mode = 2'b00; serial_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;

    do_load(8'hB5);
    do_shift("left_logic3", 4'd3, 1'b0, 2'b00, 8'hA8, 1'b1, 4'b0000, 1'b1);

    do_load(8'h96);
    do_shift("right_arith2", 4'd2, 1'b1, 2'b01, 8'hE5, 1'b1, 4'b0000, 1'b0);
    do_shift("right_logic9", 4'd9, 1'b1, 2'b00, 8'h00, 1'b0, 4'b0000, 1'b0);

    do_load(8'h81);
`ifdef SEQ_SHIFT_ROTATE_EN
    do_shift("left_rot1", 4'd1, 1'b0, 2'b10, 8'h03, 1'b1, 4'b0000, 1'b0);
    do_shift("amt_zero", 4'd0, 1'b0, 2'b00, 8'h03, 1'b1, 4'b0000, 1'b1);
`else
    do_shift("left_rot1", 4'd1, 1'b0, 2'b10, 8'h02, 1'b1, 4'b0000, 1'b0);
    do_shift("amt_zero", 4'd0, 1'b0, 2'b00, 8'h02, 1'b1, 4'b0000, 1'b1);
`endif

    do_load(8'h81);
`ifdef SEQ_SHIFT_ROTATE_EN
    do_shift("left_rot9", 4'd9, 1'b0, 2'b10, 8'h03, 1'b1, 4'b0000, 1'b0);
`else
    do_shift("left_rot9", 4'd9, 1'b0, 2'b10, 8'h00, 1'b0, 4'b0000, 1'b0);
`endif

    do_load(8'h81);
    do_shift("left_arith1", 4'd1, 1'b0, 2'b01, 8'h02, 1'b1, 4'b0000, 1'b0);

    do_load(8'h80);
    do_shift("right_arith10", 4'd10, 1'b1, 2'b01, 8'hFF, 1'b1, 4'b0000, 1'b0);

    // Serial fill 1,0,1,1 on successive shift cycles.
    do_load(8'h00);
    do_shift("right_serial4", 4'd4, 1'b1, 2'b11, 8'hD0, 1'b0, 4'b1101, 1'b1);

    // Load and start together: load wins, no shift follows.
    cur_name = "load_start";
    @(negedge clk);
    load = 1'b1; start = 1'b1; data_in = 8'h5A; amt = 4'd3; dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("load_start_data", 32'(data_out), 32'h5A);
    check("load_start_carry", 32'(carry_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("load_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    check("load_start_final", 32'(data_out), 32'h5A);

    // Reset held two cycles in the middle of a shift.
    cur_name = "reset_abort";
    do_load(8'hFF);
    @(negedge clk);
    start = 1'b1; amt = 4'd7; dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);

    do_load(8'h0F);
    do_shift("post_reset_left2", 4'd2, 1'b0, 2'b00, 8'h3C, 1'b0, 4'b0000, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
